// File: rtl/hall_pkg.sv
// hall_pkg: shared definitions for the hall speed scheduler.
//   state_e        drain FSM states (S_COUNT, S_DRAIN)
//   HALL_ILLEGAL_* hall triplets that no healthy sensor produces
//   clog2          width helper for elaboration-time sizing
package hall_pkg;

    typedef enum logic {
        S_COUNT = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    localparam logic [2:0] HALL_ILLEGAL_0 = 3'b000;
    localparam logic [2:0] HALL_ILLEGAL_1 = 3'b111;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/hall_edge_counter.sv
// hall_edge_counter: per-motor hall front end.
//   2-flop synchroniser on the raw triplet, one prev stage, transition detect,
//   saturating edge counter cleared on the gate tick (loads 1 if an edge lands
//   on the tick cycle, so that edge belongs to the next window).
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   en_i            measurement enable; counter held at 0 when low
//   tick_i          last cycle of the gate window
//   hall_i[2:0]     asynchronous hall triplet
//   cnt_o           edges seen so far in the current window
//   fault_o         (HALL_FAULT_EN only) synced triplet is 000 or 111
// Macro: HALL_FAULT_EN adds fault_o and excludes edges into/out of illegal states.
import hall_pkg::*;

module hall_edge_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic [2:0]       hall_i,
    output logic [CNT_W-1:0] cnt_o
`ifdef HALL_FAULT_EN
   ,output logic             fault_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       s1_q, s2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trans;

`ifdef HALL_FAULT_EN
    logic fault_q;
    logic ill_cur, ill_prev;

    assign ill_cur  = (s2_q == HALL_ILLEGAL_0) || (s2_q == HALL_ILLEGAL_1);
    assign ill_prev = (prev_q == HALL_ILLEGAL_0) || (prev_q == HALL_ILLEGAL_1);
    assign trans    = (s2_q != prev_q) && !ill_cur && !ill_prev;
    assign fault_o  = fault_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) fault_q <= 1'b0;
        else         fault_q <= ill_cur;
    end
`else
    assign trans = (s2_q != prev_q);
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i)
            cnt_d = '0;
        else if (tick_i)
            cnt_d = trans ? CNT_ONE : '0;
        else if (trans && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= hall_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hall_speed_scheduler.sv
// hall_speed_scheduler: shared gate timer, per-motor hall edge counters,
// window snapshot and round-robin valid/ready drain of the counts.
// Ports:
//   CLK, RST          clock, synchronous active-low reset
//   EN                measurement enable (timer/counters held at 0 when low)
//   H                 hall inputs, motor m on H[3m+2:3m]
//   SPD_VALID/READY   drain stream handshake
//   SPD_ID, SPD_CNT   motor index and its edge count from the last window
//   WIN_TICK          pulse on the last cycle of each window
//   OVERRUN           sticky: a window ended while a drain was still running
//   FAULT             (HALL_FAULT_EN only) per-motor illegal-triplet flag
// Macro: HALL_FAULT_EN enables hall fault detection and the FAULT port.
import hall_pkg::*;

module hall_speed_scheduler #(
    parameter int N_MOTORS      = 4,
    parameter int WINDOW_CYCLES = 500000,
    parameter int CNT_W         = 8,
    localparam int ID_W         = (N_MOTORS > 1) ? clog2(N_MOTORS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [3*N_MOTORS-1:0] H,
    output logic                  SPD_VALID,
    input  logic                  SPD_READY,
    output logic [ID_W-1:0]       SPD_ID,
    output logic [CNT_W-1:0]      SPD_CNT,
    output logic                  WIN_TICK,
    output logic                  OVERRUN
`ifdef HALL_FAULT_EN
   ,output logic [N_MOTORS-1:0]   FAULT
`endif
);

    localparam int              TMR_W    = clog2(WINDOW_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_MOTORS - 1);

    logic [TMR_W-1:0]                timer_q;
    logic                            win_tick;
    logic [N_MOTORS-1:0][CNT_W-1:0]  cnt;
    logic [N_MOTORS-1:0][CNT_W-1:0]  snap_q;

    state_e           state_q;
    logic             valid_q;
    logic [ID_W-1:0]  idx_q;
    logic [ID_W-1:0]  nxt_idx;
    logic [CNT_W-1:0] spd_cnt_q;
    logic             ovr_q;
    logic             hs;
    logic             last;

    // ---------------- gate timer ----------------
    assign win_tick = EN && (timer_q == TMR_LAST);

    always_ff @(posedge CLK) begin
        if (!RST)                 timer_q <= '0;
        else if (!EN || win_tick) timer_q <= '0;
        else                      timer_q <= timer_q + 1'b1;
    end

    // ---------------- per-motor counters ----------------
    for (genvar g = 0; g < N_MOTORS; g++) begin : g_mot
        hall_edge_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i   (CLK),
            .rst_ni  (RST),
            .en_i    (EN),
            .tick_i  (win_tick),
            .hall_i  (H[3*g +: 3]),
            .cnt_o   (cnt[g])
`ifdef HALL_FAULT_EN
           ,.fault_o (FAULT[g])
`endif
        );
    end

    // ---------------- drain FSM ----------------
    assign hs      = valid_q && SPD_READY;
    assign last    = (idx_q == ID_LAST);
    assign nxt_idx = idx_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_COUNT;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            spd_cnt_q <= '0;
            ovr_q     <= 1'b0;
            snap_q    <= '0;
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (win_tick) begin
                        snap_q    <= cnt;
                        state_q   <= S_DRAIN;
                        valid_q   <= 1'b1;
                        idx_q     <= '0;
                        spd_cnt_q <= cnt[0];
                    end
                end
                S_DRAIN: begin
                    if (hs && last) begin
                        // drain just finished: a coincident tick starts the next drain
                        if (win_tick) begin
                            snap_q    <= cnt;
                            idx_q     <= '0;
                            spd_cnt_q <= cnt[0];
                        end else begin
                            state_q   <= S_COUNT;
                            valid_q   <= 1'b0;
                            idx_q     <= '0;
                            spd_cnt_q <= '0;
                        end
                    end else begin
                        // snapshot is still being read out: drop the new window
                        if (win_tick) ovr_q <= 1'b1;
                        if (hs) begin
                            idx_q     <= nxt_idx;
                            spd_cnt_q <= snap_q[nxt_idx];
                        end
                    end
                end
                default: state_q <= S_COUNT;
            endcase
        end
    end

    assign SPD_VALID = valid_q;
    assign SPD_ID    = idx_q;
    assign SPD_CNT   = spd_cnt_q;
    assign WIN_TICK  = win_tick;
    assign OVERRUN   = ovr_q;

endmodule
